// File: rtl/mem_ref_unit_if.sv
// Instruction-issue, memory-handshake and architectural-state bundle for mem_ref_unit.
// The master modport is the instruction unit; the slave modport is the issuer/memory side.
interface mem_ref_unit_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12
);
  logic              i_start;
  logic [2:0]        i_opcode;
  logic              i_ind;
  logic [AWIDTH-1:0] i_addr;
  logic              i_pc_load;
  logic [AWIDTH-1:0] i_pc_val;

  logic              o_mem_req;
  logic              o_mem_we;
  logic [AWIDTH-1:0] o_mem_addr;
  logic [DWIDTH-1:0] o_mem_wdata;
  logic              i_mem_ack;
  logic [DWIDTH-1:0] i_mem_rdata;

  logic [DWIDTH-1:0] o_ac;
  logic              o_e;
  logic [AWIDTH-1:0] o_pc;
  logic              o_busy;
  logic              o_done;

  modport master (
    input  i_start, i_opcode, i_ind, i_addr, i_pc_load, i_pc_val,
    input  i_mem_ack, i_mem_rdata,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    output o_ac, o_e, o_pc, o_busy, o_done
  );

  modport slave (
    output i_start, i_opcode, i_ind, i_addr, i_pc_load, i_pc_val,
    output i_mem_ack, i_mem_rdata,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    input  o_ac, o_e, o_pc, o_busy, o_done
  );
endinterface

// File: rtl/mem_ref_unit.sv
// Memory-reference instruction unit (AND/ADD/LDA/STA/BUN/BSA/ISZ) of a basic accumulator
// machine: optional indirect address fetch, operand read, execute and write-back over a req/ack bus.
module mem_ref_unit #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12
) (
  input  logic          clk,
  input  logic          i_clr_reg,
  mem_ref_unit_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IND   = 3'd1,
    READ  = 3'd2,
    EXEC  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  localparam logic [DWIDTH-1:0] D_ONE = DWIDTH'(1);
  localparam logic [AWIDTH-1:0] A_ONE = AWIDTH'(1);

  state_t            state_reg;
  logic [2:0]        opcode_reg;
  logic [AWIDTH-1:0] ar_reg;
  logic [AWIDTH-1:0] pc_reg;
  logic [DWIDTH-1:0] ac_reg;
  logic [DWIDTH-1:0] dr_reg;
  logic              e_reg;
  logic              req_reg;
  logic              we_reg;
  logic [AWIDTH-1:0] addr_reg;
  logic [DWIDTH-1:0] wdata_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [2:0]        op_sel;
  state_t            first_state;
  logic              first_req;
  logic              first_we;
  logic [DWIDTH-1:0] first_wdata;
  logic [DWIDTH:0]   add_sum;
  logic [DWIDTH-1:0] dr_inc;
  logic              ack_take;
  logic [AWIDTH-1:0] ind_addr;

  // First state after the address is resolved; in IDLE the opcode comes straight from the port.
  always_comb begin
    op_sel      = (state_reg == IDLE) ? bus.i_opcode : opcode_reg;
    first_state = DONE;
    first_we    = 1'b0;
    first_wdata = wdata_reg;
    case (op_sel)
      OP_AND, OP_ADD, OP_LDA, OP_ISZ: first_state = READ;
      OP_STA: begin
        first_state = WRITE;
        first_we    = 1'b1;
        first_wdata = ac_reg;
      end
      OP_BSA: begin
        first_state = WRITE;
        first_we    = 1'b1;
        first_wdata = DWIDTH'(pc_reg);
      end
      OP_BUN:  first_state = EXEC;
      default: first_state = DONE;
    endcase
    first_req = (first_state == READ) || (first_state == WRITE);
  end

  assign add_sum  = {1'b0, ac_reg} + {1'b0, dr_reg};
  assign dr_inc   = dr_reg + D_ONE;
  assign ack_take = req_reg && bus.i_mem_ack;
  assign ind_addr = bus.i_mem_rdata[AWIDTH-1:0];

  always_ff @(posedge clk or posedge i_clr_reg) begin
    if (i_clr_reg) begin
      state_reg  <= IDLE;
      opcode_reg <= 3'd0;
      ar_reg     <= '0;
      pc_reg     <= '0;
      ac_reg     <= '0;
      dr_reg     <= '0;
      e_reg      <= 1'b0;
      req_reg    <= 1'b0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.i_pc_load) begin
            pc_reg <= bus.i_pc_val;
          end else if (bus.i_start) begin
            opcode_reg <= bus.i_opcode;
            ar_reg     <= bus.i_addr;
            addr_reg   <= bus.i_addr;
            busy_reg   <= 1'b1;
            // The reserved opcode never touches memory, so it also skips the indirect fetch.
            if (bus.i_ind && bus.i_opcode != OP_RSV) begin
              state_reg <= IND;
              req_reg   <= 1'b1;
              we_reg    <= 1'b0;
            end else begin
              state_reg <= first_state;
              req_reg   <= first_req;
              we_reg    <= first_we;
              wdata_reg <= first_wdata;
              done_reg  <= (first_state == DONE);
            end
          end
        end

        IND: begin
          if (ack_take) begin
            ar_reg    <= ind_addr;
            addr_reg  <= ind_addr;
            state_reg <= first_state;
            req_reg   <= first_req;
            we_reg    <= first_we;
            wdata_reg <= first_wdata;
            done_reg  <= (first_state == DONE);
          end
        end

        READ: begin
          if (ack_take) begin
            dr_reg    <= bus.i_mem_rdata;
            req_reg   <= 1'b0;
            state_reg <= EXEC;
          end
        end

        EXEC: begin
          case (opcode_reg)
            OP_AND:  ac_reg <= ac_reg & dr_reg;
            OP_ADD:  {e_reg, ac_reg} <= add_sum;
            OP_LDA:  ac_reg <= dr_reg;
            OP_BUN:  pc_reg <= ar_reg;
            default: ;
          endcase
          if (opcode_reg == OP_ISZ) begin
            dr_reg    <= dr_inc;
            state_reg <= WRITE;
            req_reg   <= 1'b1;
            we_reg    <= 1'b1;
            addr_reg  <= ar_reg;
            wdata_reg <= dr_inc;
          end else begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end

        WRITE: begin
          if (ack_take) begin
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            state_reg <= DONE;
            done_reg  <= 1'b1;
            if (opcode_reg == OP_BSA) begin
              pc_reg <= ar_reg + A_ONE;
            end else if (opcode_reg == OP_ISZ && wdata_reg == '0) begin
              pc_reg <= pc_reg + A_ONE;
            end
          end
        end

        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
          we_reg    <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_mem_req   = req_reg;
  assign bus.o_mem_we    = we_reg;
  assign bus.o_mem_addr  = addr_reg;
  assign bus.o_mem_wdata = wdata_reg;
  assign bus.o_ac        = ac_reg;
  assign bus.o_e         = e_reg;
  assign bus.o_pc        = pc_reg;
  assign bus.o_busy      = busy_reg;
  assign bus.o_done      = done_reg;

endmodule

// File: tb/tb_mem_ref_unit.sv
// Directed bench for mem_ref_unit: req/ack memory with programmable ack delay, an
// instruction-level reference model, and literal checks of the documented scenarios.
module tb_mem_ref_unit;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  mem_ref_unit_if #(.DWIDTH(16), .AWIDTH(12)) bus ();

  mem_ref_unit #(.DWIDTH(16), .AWIDTH(12)) dut (
    .clk       (clk),
    .i_clr_reg (clr),
    .bus       (bus)
  );

  typedef struct {
    logic [11:0] addr;
    logic        we;
    logic [15:0] wdata;
    int          len;
  } xfer_t;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem     [4096];
  logic [15:0] ref_mem [4096];
  xfer_t got_q[$];
  xfer_t exp_q[$];

  logic [15:0] m_ac = '0;
  logic        m_e  = 1'b0;
  logic [11:0] m_pc = '0;
  bit          chk_en = 1'b0;

  int          ack_delay = 0;
  int          cur_len   = 0;
  bit          spur_ack  = 1'b0;
  logic [11:0] s_addr;
  logic        s_we;
  logic [15:0] s_wdata;
  logic        ack_now;
  logic [15:0] rd_now;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory side: acks after ack_delay wait cycles and checks the request stays frozen until then.
  always @(negedge clk) begin
    ack_now = 1'b0;
    rd_now  = 16'h0000;
    if (clr) begin
      cur_len = 0;
    end else if (!bus.o_mem_req) begin
      if (cur_len != 0) chk("req_held_until_ack", {31'b0, bus.o_mem_req}, 32'd1);
      cur_len = 0;
    end else begin
      cur_len++;
      if (cur_len > 1) begin
        chk("stable_addr", {20'b0, bus.o_mem_addr}, {20'b0, s_addr});
        chk("stable_we", {31'b0, bus.o_mem_we}, {31'b0, s_we});
        chk("stable_wdata", {16'b0, bus.o_mem_wdata}, {16'b0, s_wdata});
      end
      s_addr  = bus.o_mem_addr;
      s_we    = bus.o_mem_we;
      s_wdata = bus.o_mem_wdata;
      if (cur_len > ack_delay) begin
        ack_now = 1'b1;
        got_q.push_back('{addr: bus.o_mem_addr, we: bus.o_mem_we, wdata: bus.o_mem_wdata, len: cur_len});
        if (bus.o_mem_we) mem[bus.o_mem_addr] = bus.o_mem_wdata;
        else rd_now = mem[bus.o_mem_addr];
        cur_len = 0;
      end
    end
    bus.i_mem_ack   = ack_now | spur_ack;
    bus.i_mem_rdata = spur_ack ? 16'hDEAD : rd_now;
  end

  // Architectural state must match the model whenever the unit is idle.
  always @(negedge clk) begin
    if (chk_en && !clr && !bus.o_busy) begin
      chk("idle_ac", {16'b0, bus.o_ac}, {16'b0, m_ac});
      chk("idle_e", {31'b0, bus.o_e}, {31'b0, m_e});
      chk("idle_pc", {20'b0, bus.o_pc}, {20'b0, m_pc});
      chk("idle_req", {31'b0, bus.o_mem_req}, 32'd0);
      chk("idle_done", {31'b0, bus.o_done}, 32'd0);
    end
  end

  task automatic preload(input logic [11:0] a, input logic [15:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  task automatic load_pc(input logic [11:0] v);
    @(posedge clk); #1;
    bus.i_pc_load = 1'b1;
    bus.i_pc_val  = v;
    @(posedge clk); #1;
    bus.i_pc_load = 1'b0;
    m_pc = v;
    chk("pc_load", {20'b0, bus.o_pc}, {20'b0, v});
  endtask

  task automatic push_exp(input logic [11:0] a, input logic we, input logic [15:0] wd);
    exp_q.push_back('{addr: a, we: we, wdata: wd, len: 0});
  endtask

  // Issue one instruction, predict its effect from the instruction semantics, compare afterwards.
  task automatic run(input logic [2:0] op, input logic ind, input logic [11:0] a,
                     input int dly, input bit poke, output int lat);
    logic [11:0] ea;
    logic [15:0] v;
    logic [15:0] n_ac;
    logic        n_e;
    logic [11:0] n_pc;
    int          exp_lat;
    int          cyc;
    exp_q.delete();
    got_q.delete();
    ack_delay = dly;
    n_ac = m_ac; n_e = m_e; n_pc = m_pc; ea = a;
    if (ind && op != 3'd7) begin
      push_exp(a, 1'b0, 16'h0);
      ea = ref_mem[a][11:0];
    end
    case (op)
      3'd0, 3'd1, 3'd2: begin
        push_exp(ea, 1'b0, 16'h0);
        v = ref_mem[ea];
        if (op == 3'd0) n_ac = m_ac & v;
        else if (op == 3'd1) {n_e, n_ac} = {1'b0, m_ac} + {1'b0, v};
        else n_ac = v;
      end
      3'd3: begin
        push_exp(ea, 1'b1, m_ac);
        ref_mem[ea] = m_ac;
      end
      3'd4: n_pc = ea;
      3'd5: begin
        push_exp(ea, 1'b1, {4'h0, m_pc});
        ref_mem[ea] = {4'h0, m_pc};
        n_pc = ea + 12'd1;
      end
      3'd6: begin
        push_exp(ea, 1'b0, 16'h0);
        v = ref_mem[ea] + 16'd1;
        push_exp(ea, 1'b1, v);
        ref_mem[ea] = v;
        if (v == 16'h0000) n_pc = m_pc + 12'd1;
      end
      default: ;
    endcase
    exp_lat = 1 + exp_q.size() * (1 + dly) + ((op <= 3'd2 || op == 3'd4 || op == 3'd6) ? 1 : 0);

    @(posedge clk); #1;
    bus.i_start  = 1'b1;
    bus.i_opcode = op;
    bus.i_ind    = ind;
    bus.i_addr   = a;
    cyc = 0;
    lat = -1;
    while (cyc < 300 && lat < 0) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        bus.i_start = 1'b0;
        chk("busy_after_start", {31'b0, bus.o_busy}, 32'd1);
      end
      if (poke && cyc == 2) begin
        bus.i_start  = 1'b1;
        bus.i_opcode = 3'd4;
        bus.i_ind    = 1'b0;
        bus.i_addr   = 12'h555;
      end
      if (poke && cyc == 3) bus.i_start = 1'b0;
      if (bus.o_done) lat = cyc;
    end
    bus.i_start = 1'b0;
    m_ac = n_ac; m_e = n_e; m_pc = n_pc;
    chk("latency", lat, exp_lat);
    chk("xfer_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk("xfer_addr", {20'b0, got_q[i].addr}, {20'b0, exp_q[i].addr});
      chk("xfer_we", {31'b0, got_q[i].we}, {31'b0, exp_q[i].we});
      if (exp_q[i].we) chk("xfer_wdata", {16'b0, got_q[i].wdata}, {16'b0, exp_q[i].wdata});
      chk("xfer_req_cycles", got_q[i].len, dly + 1);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, bus.o_done}, 32'd0);
    chk("idle_after_done", {31'b0, bus.o_busy}, 32'd0);
    $display("txn op=%0d ind=%0d addr=%03h delay=%0d lat=%0d ac=%04h e=%0d pc=%03h xfers=%0d",
             op, ind, a, dly, lat, bus.o_ac, bus.o_e, bus.o_pc, got_q.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    bus.i_start = 1'b0; bus.i_opcode = 3'd0; bus.i_ind = 1'b0; bus.i_addr = '0;
    bus.i_pc_load = 1'b0; bus.i_pc_val = '0;
    bus.i_mem_ack = 1'b0; bus.i_mem_rdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ac", {16'b0, bus.o_ac}, 32'd0);
    chk("rst_e", {31'b0, bus.o_e}, 32'd0);
    chk("rst_pc", {20'b0, bus.o_pc}, 32'd0);
    chk("rst_req", {31'b0, bus.o_mem_req}, 32'd0);
    chk("rst_we", {31'b0, bus.o_mem_we}, 32'd0);
    chk("rst_addr", {20'b0, bus.o_mem_addr}, 32'd0);
    chk("rst_wdata", {16'b0, bus.o_mem_wdata}, 32'd0);
    chk("rst_busy", {31'b0, bus.o_busy}, 32'd0);
    chk("rst_done", {31'b0, bus.o_done}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    chk_en = 1'b1;

    preload(12'h001, 16'hFFFF);
    preload(12'h010, 16'h0002);
    preload(12'h020, 16'h0123);
    preload(12'h123, 16'hBEEF);
    preload(12'h030, 16'hFFFF);
    preload(12'h031, 16'h0005);
    preload(12'h040, 16'h0F0F);
    preload(12'h060, 16'h0031);

    run(3'd2, 1'b0, 12'h001, 0, 1'b0, lat);
    chk("lda_ffff_lit", {16'b0, bus.o_ac}, 32'h0000FFFF);

    run(3'd1, 1'b0, 12'h010, 0, 1'b0, lat);
    chk("add_ac_lit", {16'b0, bus.o_ac}, 32'h00000001);
    chk("add_e_lit", {31'b0, bus.o_e}, 32'd1);
    chk("add_lat_lit", lat, 32'd3);

    run(3'd2, 1'b1, 12'h020, 0, 1'b0, lat);
    chk("lda_ind_ac_lit", {16'b0, bus.o_ac}, 32'h0000BEEF);
    chk("lda_ind_lat_lit", lat, 32'd4);
    if (got_q.size() == 2) begin
      chk("lda_ind_a0_lit", {20'b0, got_q[0].addr}, 32'h020);
      chk("lda_ind_a1_lit", {20'b0, got_q[1].addr}, 32'h123);
    end

    run(3'd0, 1'b0, 12'h040, 0, 1'b0, lat);
    chk("and_ac_lit", {16'b0, bus.o_ac}, 32'h00000E0F);
    chk("and_keeps_e_lit", {31'b0, bus.o_e}, 32'd1);

    load_pc(12'h100);
    run(3'd6, 1'b0, 12'h030, 0, 1'b0, lat);
    chk("isz_wrap_mem_lit", {16'b0, mem[12'h030]}, 32'h0);
    chk("isz_wrap_pc_lit", {20'b0, bus.o_pc}, 32'h101);
    load_pc(12'h100);
    run(3'd6, 1'b0, 12'h031, 0, 1'b0, lat);
    chk("isz_mem_lit", {16'b0, mem[12'h031]}, 32'h6);
    chk("isz_pc_lit", {20'b0, bus.o_pc}, 32'h100);

    load_pc(12'h0FF);
    run(3'd5, 1'b0, 12'h200, 0, 1'b0, lat);
    chk("bsa_mem_lit", {16'b0, mem[12'h200]}, 32'h00FF);
    chk("bsa_pc_lit", {20'b0, bus.o_pc}, 32'h201);
    run(3'd5, 1'b0, 12'hFFF, 0, 1'b0, lat);
    chk("bsa_wrap_pc_lit", {20'b0, bus.o_pc}, 32'h000);

    run(3'd3, 1'b0, 12'h050, 3, 1'b1, lat);
    chk("sta_mem_lit", {16'b0, mem[12'h050]}, 32'h0E0F);
    chk("sta_lat_lit", lat, 32'd5);

    run(3'd4, 1'b1, 12'h020, 0, 1'b0, lat);
    chk("bun_ind_pc_lit", {20'b0, bus.o_pc}, 32'h123);
    run(3'd7, 1'b1, 12'h020, 0, 1'b0, lat);
    chk("rsv_lat_lit", lat, 32'd1);
    run(3'd1, 1'b1, 12'h020, 2, 1'b0, lat);
    chk("add_ind_dly_ac_lit", {16'b0, bus.o_ac}, 32'h0000CCFE);
    run(3'd6, 1'b1, 12'h060, 1, 1'b0, lat);
    chk("isz_ind_mem_lit", {16'b0, mem[12'h031]}, 32'h7);

    // Reset while the operand read is still waiting for its ack.
    ack_delay = 100;
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_opcode = 3'd2; bus.i_ind = 1'b0; bus.i_addr = 12'h010;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    @(posedge clk); #1;
    chk("req_in_read", {31'b0, bus.o_mem_req}, 32'd1);
    @(negedge clk); #2;
    clr = 1'b1;
    m_ac = '0; m_e = 1'b0; m_pc = '0;
    #1;
    chk("clr_req", {31'b0, bus.o_mem_req}, 32'd0);
    chk("clr_we", {31'b0, bus.o_mem_we}, 32'd0);
    chk("clr_addr", {20'b0, bus.o_mem_addr}, 32'd0);
    chk("clr_wdata", {16'b0, bus.o_mem_wdata}, 32'd0);
    chk("clr_ac", {16'b0, bus.o_ac}, 32'd0);
    chk("clr_e", {31'b0, bus.o_e}, 32'd0);
    chk("clr_pc", {20'b0, bus.o_pc}, 32'd0);
    chk("clr_busy", {31'b0, bus.o_busy}, 32'd0);
    chk("clr_done", {31'b0, bus.o_done}, 32'd0);
    @(negedge clk); #2;
    clr = 1'b0;
    @(posedge clk); #1;
    spur_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    spur_ack = 1'b0;
    chk("late_ack_busy", {31'b0, bus.o_busy}, 32'd0);
    chk("late_ack_ac", {16'b0, bus.o_ac}, 32'd0);
    chk("late_ack_req", {31'b0, bus.o_mem_req}, 32'd0);
    $display("txn clr mid-read, late ack: ac=%04h busy=%0d", bus.o_ac, bus.o_busy);

    run(3'd2, 1'b0, 12'h001, 0, 1'b0, lat);
    chk("post_clr_lda_lit", {16'b0, bus.o_ac}, 32'h0000FFFF);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ref_unit.md
MEM_REF_UNIT -- requirements
Module: mem_ref_unit

Interface
REQ-001 Parameter DWIDTH, default 16, data word / AC / DR width.
REQ-002 Parameter AWIDTH, default 12, address / AR / PC width; AWIDTH SHALL be <= DWIDTH.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 i_clr_reg  input  1  reset, asynchronous, active-high.
REQ-005 i_start  input  1  start one memory-reference instruction; sampled only in IDLE.
REQ-006 i_opcode  input  3  0 AND, 1 ADD, 2 LDA, 3 STA, 4 BUN, 5 BSA, 6 ISZ, 7 reserved.
REQ-007 i_ind  input  1  indirect-addressing flag (I bit).
REQ-008 i_addr  input  AWIDTH  effective address field.
REQ-009 i_pc_load / i_pc_val  input  1 / AWIDTH  PC preload, honoured only in IDLE.
REQ-010 o_mem_req, o_mem_we  output  1 each  memory request, write enable.
REQ-011 o_mem_addr / o_mem_wdata  output  AWIDTH / DWIDTH  request address / write data.
REQ-012 i_mem_ack / i_mem_rdata  input  1 / DWIDTH  transfer complete / read data (valid with ack).
REQ-013 o_ac, o_e, o_pc  output  DWIDTH, 1, AWIDTH  architectural AC, E, PC.
REQ-014 o_busy, o_done  output  1 each  not-IDLE; one-cycle completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, IND, READ, EXEC, WRITE, DONE; all outputs registered.
REQ-016 IDLE: i_start=1 latches opcode, ind, addr (AR<=i_addr) and moves to IND if i_ind else to the opcode's first state; i_pc_load has priority over i_start.
REQ-017 i_start outside IDLE SHALL be ignored; no queueing.
REQ-018 Handshake: req/we/addr/wdata held stable from state entry until the edge sampling req&&ack; ack allowed in the first req cycle; req deasserts the following cycle; ack without req ignored.
REQ-019 IND: read at AR; on ack AR <= i_mem_rdata[AWIDTH-1:0]; then first opcode state.
REQ-020 AND, ADD, LDA, ISZ: READ at AR; on ack DR <= i_mem_rdata; then EXEC.
REQ-021 EXEC AND: AC <= AC & DR; ADD: {E,AC} <= AC + DR (carry-out to E, sum mod 2^DWIDTH); LDA: AC <= DR; then DONE.
REQ-022 EXEC ISZ: DR <= DR+1 mod 2^DWIDTH; then WRITE of new DR at AR; if new DR == 0, PC <= PC+1 mod 2^AWIDTH at write-ack edge.
REQ-023 STA: WRITE of AC at AR, then DONE; AC, E, PC unchanged.
REQ-024 BUN: EXEC sets PC <= AR, no memory access, then DONE.
REQ-025 BSA: WRITE of PC zero-extended to DWIDTH at AR; at ack PC <= AR+1 mod 2^AWIDTH; then DONE.
REQ-026 Opcode 7: straight to DONE, no memory access, no state change.
REQ-027 E SHALL change only on ADD; AC only on AND/ADD/LDA.
REQ-028 DONE: o_done=1 exactly one cycle, o_busy=1, then IDLE; o_busy=0 only in IDLE.
REQ-029 Latency with ack in first req cycle: direct LDA/ADD/AND o_done 3 cycles after start edge; each indirect level +1 cycle; each ack wait cycle +1.

Reset
REQ-030 i_clr_reg=1 SHALL immediately force IDLE, AC/DR=0, AR/PC=0, E=0, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_busy=0, o_done=0.
REQ-031 Reset mid-transaction abandons the access; a later ack SHALL be ignored.

Verification
REQ-032 DWIDTH=16: AC=0xFFFF, E=0, mem[0x010]=0x0002, ADD direct 0x010, ack immediate -> AC=0x0001, E=1, o_done 3 cycles after start.
REQ-033 LDA indirect 0x020, mem[0x020]=0x0123, mem[0x123]=0xBEEF -> reads 0x020 then 0x123, AC=0xBEEF, done 4 cycles after start.
REQ-034 ISZ 0x030, mem[0x030]=0xFFFF, PC=0x100 -> writes 0x0000 to 0x030, PC=0x101; with 0x0005 -> writes 0x0006, PC=0x100.
REQ-035 PC=0x0FF, BSA 0x200 -> mem[0x200]=0x00FF written, PC=0x201; BSA 0xFFF -> PC wraps to 0x000.
REQ-036 STA with ack delayed 3 cycles -> req/addr/wdata stable for 4 cycles; i_start pulsed while busy ignored.
REQ-037 i_clr_reg asserted mid-READ -> req drops same cycle, all outputs zero, late ack produces no state change.
